// File: rtl/ws2812_pkg.sv
// Shared types and timing helpers for the WS2812 chain driver.
// All pulse widths are whole clk cycles derived from the clock frequency in MHz.
package ws2812_pkg;

    typedef logic [23:0] rgb_t;

    typedef enum logic {
        STATE_DATA  = 1'b0,
        STATE_RESET = 1'b1
    } state_e;

    localparam int unsigned BitsPerLed = 24;

    // High time of a 1-bit (~900 ns), truncated to whole cycles.
    function automatic int unsigned t_on(input int unsigned clk_mhz);
        return clk_mhz * 900 / 1000;
    endfunction

    // High time of a 0-bit (~350 ns), truncated to whole cycles.
    function automatic int unsigned t_off(input int unsigned clk_mhz);
        return clk_mhz * 350 / 1000;
    endfunction

    // Latch gap between frames (~280 us).
    function automatic int unsigned t_reset(input int unsigned clk_mhz);
        return clk_mhz * 280;
    endfunction

    function automatic int unsigned t_bit(input int unsigned clk_mhz);
        return t_on(clk_mhz) + t_off(clk_mhz);
    endfunction

    function automatic int unsigned frame_cycles(input int unsigned num_leds,
                                                 input int unsigned clk_mhz);
        return num_leds * BitsPerLed * t_bit(clk_mhz) + t_reset(clk_mhz);
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// NRZ encoder for one WS2812 bit period: a high pulse whose width depends on the bit value,
// followed by low time, with a done strobe on the last cycle of the period.
module ws2812_bit_encoder
    import ws2812_pkg::*;
#(
    parameter int unsigned CLK_MHZ = 12
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic start_i,
    input  logic bit_i,
    output logic data_o,
    output logic bit_done_o
);

    localparam int unsigned TOn  = t_on(CLK_MHZ);
    localparam int unsigned TOff = t_off(CLK_MHZ);
    localparam int unsigned TBit = TOn + TOff;
    localparam int unsigned CntW = (TBit > 1) ? $clog2(TBit) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TBit - 1);

    logic [CntW-1:0] clk_counter_q, clk_counter_d;
    logic [31:0]     high_cycles;

    // Bit periods run back to back while start_i is held; dropping it parks the counter at 0.
    always_comb begin
        high_cycles   = bit_i ? TOn : TOff;
        bit_done_o    = start_i && (clk_counter_q == CntLast);
        data_o        = start_i && (32'(clk_counter_q) < high_cycles);
        clk_counter_d = '0;
        if (start_i && !bit_done_o) begin
            clk_counter_d = clk_counter_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            clk_counter_q <= '0;
        end else begin
            clk_counter_q <= clk_counter_d;
        end
    end

endmodule

// File: rtl/ws2812.sv
// Self-refreshing WS2812 chain driver: per-LED colour register file, continuously
// serialised LED 0 first, with a latch gap between frames.
module ws2812
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 8,
    parameter int unsigned CLK_MHZ  = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] rgb_data,
    input  logic [7:0]  led_num,
    input  logic        write,
    output logic        data
);

    localparam int unsigned TReset = t_reset(CLK_MHZ);
    localparam int unsigned LedW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int unsigned RstW   = (TReset > 1) ? $clog2(TReset) : 1;
    localparam logic [LedW-1:0] LastLed = LedW'(NUM_LEDS - 1);
    localparam logic [RstW-1:0] RstLast = RstW'(TReset - 1);
    localparam logic [4:0]      TopBit  = 5'(BitsPerLed - 1);

    rgb_t            led_reg_q [NUM_LEDS];
    rgb_t            current_word_q, current_word_d;
    state_e          state_q, state_d;
    logic [LedW-1:0] led_counter_q, led_counter_d;
    logic [4:0]      bit_counter_q, bit_counter_d;
    logic [RstW-1:0] reset_cnt_q, reset_cnt_d;
    logic            capture;
    logic [LedW-1:0] capture_idx;
    logic            enc_start;
    logic            enc_bit;
    logic            bit_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_LEDS); i++) begin
                led_reg_q[i] <= '0;
            end
        end else if (write && ({24'd0, led_num} < NUM_LEDS)) begin
            led_reg_q[led_num[LedW-1:0]] <= rgb_data;
        end
    end

    always_comb begin
        state_d       = state_q;
        led_counter_d = led_counter_q;
        bit_counter_d = bit_counter_q;
        reset_cnt_d   = reset_cnt_q;
        capture       = 1'b0;
        unique case (state_q)
            STATE_RESET: begin
                if (reset_cnt_q == RstLast) begin
                    state_d       = STATE_DATA;
                    led_counter_d = LastLed;
                    bit_counter_d = TopBit;
                    reset_cnt_d   = '0;
                    capture       = 1'b1;
                end else begin
                    reset_cnt_d = reset_cnt_q + RstW'(1);
                end
            end
            STATE_DATA: begin
                if (bit_done) begin
                    if (bit_counter_q != 5'd0) begin
                        bit_counter_d = bit_counter_q - 5'd1;
                    end else if (led_counter_q != '0) begin
                        led_counter_d = led_counter_q - LedW'(1);
                        bit_counter_d = TopBit;
                        capture       = 1'b1;
                    end else begin
                        state_d       = STATE_RESET;
                        led_counter_d = '0;
                        bit_counter_d = '0;
                    end
                end
            end
        endcase
    end

    // The word is latched on the edge that starts its bit 23, so later writes wait a frame.
    always_comb begin
        capture_idx    = LastLed - led_counter_d;
        current_word_d = capture ? led_reg_q[capture_idx] : current_word_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= STATE_RESET;
            led_counter_q  <= '0;
            bit_counter_q  <= '0;
            reset_cnt_q    <= '0;
            current_word_q <= '0;
        end else begin
            state_q        <= state_d;
            led_counter_q  <= led_counter_d;
            bit_counter_q  <= bit_counter_d;
            reset_cnt_q    <= reset_cnt_d;
            current_word_q <= current_word_d;
        end
    end

    always_comb begin
        enc_start = (state_q == STATE_DATA);
        enc_bit   = current_word_q[bit_counter_q];
    end

    ws2812_bit_encoder #(
        .CLK_MHZ(CLK_MHZ)
    ) u_bit_encoder (
        .clk_i     (clk),
        .reset_i   (reset),
        .start_i   (enc_start),
        .bit_i     (enc_bit),
        .data_o    (data),
        .bit_done_o(bit_done)
    );

endmodule

// File: tb/tb_ws2812.sv
// Bench for ws2812 (4 LEDs, 12 MHz): register-file vector table, then a cycle-accurate
// frame-position model of the expected waveform under directed and random writes.
module tb_ws2812;

    localparam int unsigned NLeds  = 4;
    localparam int unsigned ClkMhz = 12;
    localparam int TOn     = 10;
    localparam int TOff    = 4;
    localparam int TBit    = 14;
    localparam int TRes    = 3360;
    localparam int WordCyc = 24 * TBit;
    localparam int Frame   = TRes + 4 * WordCyc;

    logic        clk = 1'b0;
    logic        reset;
    logic        write;
    logic [7:0]  led_num;
    logic [23:0] rgb_data;
    logic        data;

    ws2812 #(
        .NUM_LEDS(NLeds),
        .CLK_MHZ (ClkMhz)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rgb_data(rgb_data),
        .led_num (led_num),
        .write   (write),
        .data    (data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [7:0]  num;
        logic [23:0] val;
        int          chk;
        logic [23:0] exp;
    } vec_t;

    vec_t        tbl [7];
    int          vectors = 0;
    int          miscompares = 0;
    logic [23:0] mreg [NLeds];
    logic [23:0] snap [NLeds];
    int          t = 0;
    bit          model_valid = 1'b0;

    // Expected line level at position pos within a frame (gap first, then LED 0..3 words).
    function automatic logic exp_data(input int pos);
        int          d;
        int          b;
        int          c;
        logic [23:0] w;
        if (pos < TRes) return 1'b0;
        d = pos - TRes;
        w = snap[d / WordCyc];
        b = 23 - (d % WordCyc) / TBit;
        c = d % TBit;
        return (c < (w[b] ? TOn : TOff));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0d: got %0h expected %0h", name, t, act, exp);
        end
    endtask

    task automatic tick();
        int pos;
        int nxt;
        @(negedge clk);
        if (model_valid) begin
            pos = t % Frame;
            check("data", 32'(data), 32'(exp_data(pos)));
            check("state", 32'(dut.state_q), 32'(pos < TRes));
            if (pos == 0 && t > 0) check("led_counter_frame_end", 32'(dut.led_counter_q), 0);
            if (pos == TRes) check("led_counter_frame_start", 32'(dut.led_counter_q), NLeds - 1);
            nxt = (t + 1) % Frame;
            if (nxt >= TRes && (nxt - TRes) % WordCyc == 0) begin
                snap[(nxt - TRes) / WordCyc] = mreg[(nxt - TRes) / WordCyc];
            end
        end
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < int'(NLeds); i++) mreg[i] = 24'h0;
            t = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (write && led_num < 8'(NLeds)) mreg[led_num[1:0]] = rgb_data;
            t++;
        end
        #1;
    endtask

    task automatic cycle(input logic w, input logic [7:0] n, input logic [23:0] v);
        write = w;
        led_num = n;
        rgb_data = v;
        tick();
        write = 1'b0;
    endtask

    task automatic run_to(input int target);
        while (t < target) tick();
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'd0,   24'hAACCDD, 0, 24'hAACCDD};
        tbl[1] = '{1'b1, 8'd7,   24'hFFFFFF, 3, 24'h000000};
        tbl[2] = '{1'b1, 8'd4,   24'h123456, 0, 24'hAACCDD};
        tbl[3] = '{1'b0, 8'd1,   24'h5A5A5A, 1, 24'h000000};
        tbl[4] = '{1'b1, 8'd3,   24'h00F00F, 3, 24'h00F00F};
        tbl[5] = '{1'b1, 8'd3,   24'h000000, 3, 24'h000000};
        tbl[6] = '{1'b1, 8'd255, 24'hFFFFFF, 3, 24'h000000};

        reset = 1'b1;
        write = 1'b0;
        led_num = 8'd0;
        rgb_data = 24'h0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].wr, tbl[i].num, tbl[i].val);
            check("regfile_vec", 32'(dut.led_reg_q[tbl[i].chk]), 32'(tbl[i].exp));
        end

        // Six identical refresh frames with LED 0 = AACCDD, the rest dark.
        run_to(6 * Frame);

        // Write LED 0 while its word is on the wire: old value this frame, new one next.
        run_to(6 * Frame + TRes + 100);
        cycle(1'b1, 8'd0, 24'h000001);

        // Write LED 1 in the very cycle its word is captured: old value still goes out.
        run_to(7 * Frame + TRes + WordCyc - 1);
        cycle(1'b1, 8'd1, 24'h800000);

        run_to(8 * Frame);
        while (t < 10 * Frame) begin
            if ($urandom_range(0, 63) == 0) begin
                cycle(1'b1, 8'($urandom_range(0, 7)), 24'($urandom));
            end else begin
                tick();
            end
        end

        // Reset in the middle of a bit's high phase.
        run_to(10 * Frame + TRes + 3 * TBit + 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_data", 32'(data), 0);
        check("reset_state", 32'(dut.state_q), 1);
        for (int i = 0; i < int'(NLeds); i++) begin
            check("reset_regfile", 32'(dut.led_reg_q[i]), 0);
        end
        cycle(1'b1, 8'd0, 24'h800001);
        cycle(1'b1, 8'd2, 24'hF0F0F0);
        run_to(TRes + 3 * WordCyc + 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
